// File: rtl/dm_arbiter.sv
// Data Memory arbiter: CPU MEM stage has priority, loader is protected by a
// starvation counter and may own the memory for a bounded burst.
`timescale 1ns/1ps
module dm_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_last,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_gnt,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_w,
  output logic              dm_r,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              ldr_owner
);

  typedef enum logic {S_CPU, S_LDR} state_t;

  localparam logic [3:0] STARVE_LIM = STARVE_LIMIT[3:0];
  localparam logic [3:0] BURST_LIM  = BURST_MAX[3:0];
  localparam logic       MULTI_BEAT = (BURST_MAX > 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] beat_cnt;
  logic       starve_hit;
  logic       ldr_gnt_raw;
  logic       cpu_gnt_raw;

  assign starve_hit = (starve_cnt == STARVE_LIM);

  always_comb begin
    ldr_gnt_raw = 1'b0;
    cpu_gnt_raw = 1'b0;
    if (state == S_LDR) begin
      ldr_gnt_raw = ldr_req;
    end else begin
      ldr_gnt_raw = ldr_req & (~cpu_req | starve_hit);
      cpu_gnt_raw = cpu_req & ~ldr_gnt_raw;
    end
  end

  // Grants are gated by rst_n so no DM access can slip through during reset.
  assign ldr_gnt   = rst_n & ldr_gnt_raw;
  assign cpu_gnt   = rst_n & cpu_gnt_raw;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_w     = 1'b0;
    dm_r     = 1'b0;
    if (cpu_gnt) begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_w     = cpu_we;
      dm_r     = ~cpu_we;
    end else if (ldr_gnt) begin
      dm_addr  = ldr_addr;
      dm_wdata = ldr_wdata;
      dm_w     = ldr_we;
      dm_r     = ~ldr_we;
    end
  end

  assign cpu_rdata = dm_rdata;
  assign ldr_rdata = dm_rdata;

  // Any release condition in S_LDR (last, forced, idle) returns to S_CPU once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CPU;
      starve_cnt <= 4'd0;
      beat_cnt   <= 4'd0;
      ldr_owner  <= 1'b0;
    end else begin
      if (ldr_gnt)
        starve_cnt <= 4'd0;
      else if (ldr_req && !starve_hit)
        starve_cnt <= starve_cnt + 4'd1;

      case (state)
        S_CPU: begin
          if (ldr_gnt && !ldr_last && MULTI_BEAT) begin
            state     <= S_LDR;
            beat_cnt  <= 4'd1;
            ldr_owner <= 1'b1;
          end
        end
        S_LDR: begin
          if (!ldr_req || ldr_last || (beat_cnt + 4'd1 == BURST_LIM)) begin
            state     <= S_CPU;
            beat_cnt  <= 4'd0;
            ldr_owner <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: begin
          state     <= S_CPU;
          beat_cnt  <= 4'd0;
          ldr_owner <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a behavioural data memory attached
// to the dm_* port; each task drives one scenario and checks inline.
`timescale 1ns/1ps
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_last, ldr_gnt;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_w, dm_r, ldr_owner;

  logic [31:0] mem [0:255];
  int n_cmp;
  int n_err;

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_last(ldr_last), .ldr_rdata(ldr_rdata), .ldr_gnt(ldr_gnt),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_w(dm_w), .dm_r(dm_r),
    .dm_rdata(dm_rdata), .ldr_owner(ldr_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model: combinational read, write on the clock edge.
  assign dm_rdata = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_w) mem[dm_addr[9:2]] <= dm_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_last = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    cpu_req = 1; cpu_addr = 32'h40;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h44; ldr_wdata = 32'h1234;
    repeat (2) tick();
    #2;
    n_cmp++; if (cpu_stall !== 1'b1) begin n_err++; $display("[TB] FAIL reset_stall got %b exp 1", cpu_stall); end
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL reset_cpu_gnt got %b exp 0", cpu_gnt); end
    n_cmp++; if (ldr_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ldr_gnt got %b exp 0", ldr_gnt); end
    n_cmp++; if (dm_w !== 1'b0 || dm_r !== 1'b0) begin n_err++; $display("[TB] FAIL reset_dm_wr got w=%b r=%b exp 0/0", dm_w, dm_r); end
    n_cmp++; if (ldr_owner !== 1'b0) begin n_err++; $display("[TB] FAIL reset_owner got %b exp 0", ldr_owner); end
    n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_err++; $display("[TB] FAIL reset_starve got %0d exp 0", dut.starve_cnt); end
    n_cmp++; if (mem[8'h11] !== 32'h0) begin n_err++; $display("[TB] FAIL reset_no_write got %h exp 0", mem[8'h11]); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_idle();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (dm_w !== 1'b0 || dm_r !== 1'b0) begin n_err++; $display("[TB] FAIL idle_dm_wr got w=%b r=%b exp 0/0", dm_w, dm_r); end
    n_cmp++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin n_err++; $display("[TB] FAIL idle_dm_bus got a=%h d=%h exp 0/0", dm_addr, dm_wdata); end
    n_cmp++; if (cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL idle_gnt got c=%b l=%b exp 0/0", cpu_gnt, ldr_gnt); end
    n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_err++; $display("[TB] FAIL idle_starve got %0d exp 0", dut.starve_cnt); end
    tick();
  endtask

  task automatic test_cpu_only();
    clear_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin n_err++; $display("[TB] FAIL cpu_wr_gnt got g=%b s=%b exp 1/0", cpu_gnt, cpu_stall); end
    n_cmp++; if (dm_w !== 1'b1 || dm_r !== 1'b0 || dm_addr !== 32'h10) begin n_err++; $display("[TB] FAIL cpu_wr_bus got w=%b r=%b a=%h exp 1/0/10", dm_w, dm_r, dm_addr); end
    tick();
    cpu_we = 0; cpu_wdata = 0;
    @(negedge clk);
    n_cmp++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin n_err++; $display("[TB] FAIL cpu_rd_gnt got g=%b s=%b exp 1/0", cpu_gnt, cpu_stall); end
    n_cmp++; if (dm_w !== 1'b0 || dm_r !== 1'b1) begin n_err++; $display("[TB] FAIL cpu_rd_bus got w=%b r=%b exp 0/1", dm_w, dm_r); end
    n_cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL cpu_rdata got %h exp deadbeef", cpu_rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation();
    logic exp_l;
    clear_inputs();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h20; ldr_last = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_l = (c == 4);
      n_cmp++; if (ldr_gnt !== exp_l) begin n_err++; $display("[TB] FAIL starve_ldr_gnt c%0d got %b exp %b", c, ldr_gnt, exp_l); end
      n_cmp++; if (cpu_gnt !== !exp_l || cpu_stall !== exp_l) begin n_err++; $display("[TB] FAIL starve_cpu c%0d got g=%b s=%b exp %b/%b", c, cpu_gnt, cpu_stall, !exp_l, exp_l); end
      n_cmp++; if (dut.starve_cnt !== 4'(c)) begin n_err++; $display("[TB] FAIL starve_cnt c%0d got %0d exp %0d", c, dut.starve_cnt, c); end
      tick();
    end
    ldr_req = 0; ldr_last = 0;
    @(negedge clk);
    n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_err++; $display("[TB] FAIL starve_clear got %0d exp 0", dut.starve_cnt); end
    n_cmp++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || ldr_owner !== 1'b0) begin n_err++; $display("[TB] FAIL starve_after got g=%b s=%b o=%b exp 1/0/0", cpu_gnt, cpu_stall, ldr_owner); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_burst();
    logic [31:0] words [0:2];
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      ldr_req = 1; ldr_we = 1; ldr_addr = 32'h100 + 32'(4 * c); ldr_wdata = words[c];
      ldr_last = (c == 2);
      cpu_req = (c >= 1); cpu_we = 0; cpu_addr = 32'h104;
      @(negedge clk);
      n_cmp++; if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL burst_gnt c%0d got l=%b c=%b exp 1/0", c, ldr_gnt, cpu_gnt); end
      n_cmp++; if (ldr_owner !== (c >= 1)) begin n_err++; $display("[TB] FAIL burst_owner c%0d got %b exp %b", c, ldr_owner, (c >= 1)); end
      n_cmp++; if (cpu_stall !== (c >= 1)) begin n_err++; $display("[TB] FAIL burst_stall c%0d got %b exp %b", c, cpu_stall, (c >= 1)); end
      tick();
    end
    ldr_req = 0; ldr_last = 0; ldr_we = 0;
    @(negedge clk);
    n_cmp++; if (ldr_owner !== 1'b0 || cpu_gnt !== 1'b1) begin n_err++; $display("[TB] FAIL burst_release got o=%b g=%b exp 0/1", ldr_owner, cpu_gnt); end
    n_cmp++; if (cpu_rdata !== 32'h22222222) begin n_err++; $display("[TB] FAIL burst_cpu_rdata got %h exp 22222222", cpu_rdata); end
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem[8'h40 + 8'(i)] !== words[i]) begin n_err++; $display("[TB] FAIL burst_mem%0d got %h exp %h", i, mem[8'h40 + 8'(i)], words[i]); end
    end
    tick();
  endtask

  task automatic test_forced_release();
    int  beat;
    logic exp_l, exp_c, exp_o;
    beat = 0;
    clear_inputs();
    for (int c = 0; c < 18; c++) begin
      cpu_req = (c >= 2); cpu_we = 0; cpu_addr = 32'h10;
      ldr_req = (beat < 12); ldr_we = 1; ldr_last = 0;
      ldr_addr = 32'h200 + 32'(4 * beat); ldr_wdata = 32'hA000 + 32'(beat);
      @(negedge clk);
      exp_l = (c <= 7) || (c >= 12 && c <= 15);
      exp_c = (c >= 8 && c <= 11) || (c == 17);
      exp_o = (c >= 1 && c <= 7) || (c >= 13 && c <= 16);
      n_cmp++; if (ldr_gnt !== exp_l) begin n_err++; $display("[TB] FAIL force_ldr_gnt c%0d got %b exp %b", c, ldr_gnt, exp_l); end
      n_cmp++; if (cpu_gnt !== exp_c) begin n_err++; $display("[TB] FAIL force_cpu_gnt c%0d got %b exp %b", c, cpu_gnt, exp_c); end
      n_cmp++; if (ldr_owner !== exp_o) begin n_err++; $display("[TB] FAIL force_owner c%0d got %b exp %b", c, ldr_owner, exp_o); end
      if (ldr_gnt) beat++;
      tick();
    end
    clear_inputs();
    n_cmp++; if (beat !== 12) begin n_err++; $display("[TB] FAIL force_beats got %0d exp 12", beat); end
    n_cmp++; if (mem[8'h87] !== 32'hA007) begin n_err++; $display("[TB] FAIL force_mem7 got %h exp 0000a007", mem[8'h87]); end
    n_cmp++; if (mem[8'h8B] !== 32'hA00B) begin n_err++; $display("[TB] FAIL force_mem11 got %h exp 0000a00b", mem[8'h8B]); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    clear_inputs();
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h300; ldr_wdata = 32'h1;
    @(negedge clk);
    n_cmp++; if (ldr_gnt !== 1'b1) begin n_err++; $display("[TB] FAIL rstb_beat1 got %b exp 1", ldr_gnt); end
    tick();
    ldr_addr = 32'h304; ldr_wdata = 32'h55;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
    #2;
    n_cmp++; if (ldr_owner !== 1'b1 || ldr_gnt !== 1'b1) begin n_err++; $display("[TB] FAIL rstb_beat2 got o=%b g=%b exp 1/1", ldr_owner, ldr_gnt); end
    rst_n = 0;
    #1;
    n_cmp++; if (dm_w !== 1'b0 || ldr_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL rstb_dm_w got w=%b g=%b exp 0/0", dm_w, ldr_gnt); end
    n_cmp++; if (ldr_owner !== 1'b0) begin n_err++; $display("[TB] FAIL rstb_owner got %b exp 0", ldr_owner); end
    n_cmp++; if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL rstb_stall got s=%b g=%b exp 1/0", cpu_stall, cpu_gnt); end
    tick();
    n_cmp++; if (mem[8'hC1] !== 32'h0) begin n_err++; $display("[TB] FAIL rstb_no_write got %h exp 0", mem[8'hC1]); end
    ldr_req = 0; ldr_we = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b1 || dm_r !== 1'b1) begin n_err++; $display("[TB] FAIL rstb_cpu_first got g=%b r=%b exp 1/1", cpu_gnt, dm_r); end
    n_cmp++; if (cpu_rdata !== 32'h1) begin n_err++; $display("[TB] FAIL rstb_cpu_rdata got %h exp 1", cpu_rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_idle();
    test_cpu_only();
    test_starvation();
    test_burst();
    test_forced_release();
    test_reset_mid_burst();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
